wm_multi_cycle_controller: RTL and testbench
============================================

Name: wm_multi_cycle_controller

Overview:
- Parametrised next-generation washing-machine sequencer.
- Runs a coin-started programme: fill, one or more wash/rinse repetitions, then spin.
- Phase durations are set in seconds. The seconds time-base scales with the clk_freq setting. Pause is allowed only in the phases selected by a mask, and an abort input is added.
- Sits between the coin/user-panel inputs and the valve/motor drivers; phase and status outputs feed the display.

Parameters:
- TICKS_BASE, 1_000_000, clk cycles per second when clk_freq=2'b00
- FILL_SEC, 60, fill phase length in seconds
- WASH_SEC, 300, wash phase length in seconds
- RINSE_SEC, 120, rinse phase length in seconds
- SPIN_SEC, 60, spin phase length in seconds
- MAX_WASH, 4, maximum wash+rinse repetitions
- PAUSE_MASK, 5'b10000, per-phase pause enable; bit order {SPIN,RINSE,WASH,FILL,IDLE}

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clk_freq  in  2  clock-rate select: 00=1x, 01=2x, 10=4x, 11=8x TICKS_BASE
- coin_in  in  1  start request, level-sampled
- wash_count  in  clog2(MAX_WASH+1)  requested repetitions
- timer_pause  in  1  pause request, level
- abort  in  1  cancel programme
- phase  out  3  current phase code
- busy  out  1  programme running
- paused  out  1  timer frozen by pause
- wash_done  out  1  programme complete flag

Behaviour:
- Reset (async, rst_n low) values:
  - phase=IDLE, busy=0, paused=0, wash_done=0.
  - All counters cleared.
  - Latched config cleared: freq_l=0, reps_left=0.
- Phase codes: IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4. Codes 5-7 are illegal and return to IDLE on the next edge.
- IDLE:
  - On the edge where coin_in=1 and abort=0, latch freq_l=clk_freq.
  - Latch reps_left from wash_count: 0 becomes 1; values above MAX_WASH clamp to MAX_WASH.
  - Clear wash_done and enter FILL on that edge.
- coin_in is ignored in every phase other than IDLE.
- clk_freq changes mid-programme have no effect; only freq_l is used.
- Time-base:
  - Prescaler counts 0..(TICKS_BASE<<freq_l)-1; its wrap emits a one-cycle sec_tick.
  - The seconds down-counter loads PHASE_SEC-1 on phase entry and decrements on sec_tick.
  - sec_tick when the counter is 0 ends the phase.
  - Net result: each phase occupies exactly PHASE_SEC*(TICKS_BASE<<freq_l) cycles. The prescaler restarts at 0 on each phase entry.
- Transitions:
  - FILL -> WASH.
  - WASH -> RINSE.
  - RINSE -> WASH if reps_left>1 (reps_left decrements), else RINSE -> SPIN.
  - SPIN -> IDLE; wash_done=1 on that same edge.
- wash_done holds 1 until the next accepted coin or an abort.
- busy=1 whenever phase is not IDLE.
- Pause:
  - When timer_pause=1 and PAUSE_MASK[phase]=1, the prescaler and seconds counter hold and paused=1. The phase is unchanged.
  - Release resumes from the held count with no lost or extra cycles.
  - timer_pause has no effect in unmasked phases.
- Abort:
  - abort=1 on any edge forces phase=IDLE and wash_done=0, and clears all counters.
  - abort has priority over coin, pause and phase completion.
- A pause and phase end on the same cycle: pause wins, so the phase does not end.
- Width rules: the prescaler width is clog2(TICKS_BASE*8); the seconds counter width is clog2 of the largest *_SEC value. Counters never wrap past their terminal values.

Decomposition:
- Package wm_pkg holds:
  - phase localparams IDLE..SPIN and a PHASE_W=3 constant;
  - freq multiplier helper (shift by freq_l);
  - clog2 helper function.
- Sub-module wm_sec_timer holds the prescaler and seconds down-counter.
  - Inputs: load, load_val, hold, freq_l.
  - Outputs: sec_tick, expire.
- The top level holds the FSM, config latches and outputs.

Test Plan (bench params: TICKS_BASE=4, FILL=2, WASH=3, RINSE=2, SPIN=2, MAX_WASH=4, PAUSE_MASK=5'b10000):
- Single programme: reset, clk_freq=0, wash_count=1, one-cycle coin -> FILL 8 cycles, WASH 12, RINSE 8, SPIN 8; wash_done rises 36 cycles after FILL entry; busy drops on the same edge.
- Repetitions and clamping: wash_count=3 -> WASH/RINSE alternates 3 times, total 2+3*5+2=19 s=76 cycles. wash_count=0 gives 36 cycles; wash_count=7 behaves as 4 (96 cycles).
- Frequency scaling: clk_freq=2'b11 -> each second is 32 cycles, total 288 cycles. Toggling clk_freq mid-run leaves timing unchanged.
- Pause: assert timer_pause 10 cycles in WASH -> no effect. Assert 10 cycles in SPIN -> paused=1 and SPIN lengthens to exactly 18 cycles.
- Abort and priority: abort in RINSE -> IDLE next edge, counters zero, wash_done=0. coin and abort together in IDLE -> stays IDLE.
- Reset mid-programme and ignored coin: coin during WASH is ignored. rst_n low asynchronously in SPIN -> all outputs reset immediately.

Source files
------------

// File: rtl/wm_pkg.sv
// Shared phase codes and sizing helpers for the washing-machine sequencer.
package wm_pkg;

    localparam int unsigned PHASE_W = 3;

    localparam logic [PHASE_W-1:0] IDLE  = 3'd0;
    localparam logic [PHASE_W-1:0] FILL  = 3'd1;
    localparam logic [PHASE_W-1:0] WASH  = 3'd2;
    localparam logic [PHASE_W-1:0] RINSE = 3'd3;
    localparam logic [PHASE_W-1:0] SPIN  = 3'd4;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((r < 32) && ((64'd1 << r) < 64'(value))) begin
            r++;
        end
        return r;
    endfunction

    // Cycles per second for the latched clock-rate select.
    function automatic int unsigned freq_mult(input int unsigned base, input logic [1:0] freq_l);
        return base << freq_l;
    endfunction

endpackage

// File: rtl/wm_sec_timer.sv
// Prescaler plus seconds down-counter; expire pulses on the final tick of a phase.
module wm_sec_timer
    import wm_pkg::*;
#(
    parameter int unsigned TICKS_BASE = 1_000_000,
    parameter int unsigned PRE_W      = 23,
    parameter int unsigned SEC_W      = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [SEC_W-1:0] load_val,
    input  logic             hold,
    input  logic [1:0]       freq_l,
    output logic             sec_tick,
    output logic             expire
);

    logic [PRE_W-1:0] pre_cnt;
    logic [PRE_W-1:0] pre_last;
    logic [SEC_W-1:0] sec_cnt;

    assign pre_last = PRE_W'(freq_mult(TICKS_BASE, freq_l) - 1);
    assign sec_tick = !hold && (pre_cnt == pre_last);
    assign expire   = sec_tick && (sec_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            sec_cnt <= '0;
        end else if (load) begin
            pre_cnt <= '0;
            sec_cnt <= load_val;
        end else if (sec_tick) begin
            pre_cnt <= '0;
            if (sec_cnt != '0) begin
                sec_cnt <= sec_cnt - 1'b1;
            end
        end else if (!hold) begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wm_multi_cycle_controller.sv
// Coin-started fill / wash-rinse / spin sequencer with masked pause and abort.
module wm_multi_cycle_controller
    import wm_pkg::*;
#(
    parameter int unsigned TICKS_BASE = 1_000_000,
    parameter int unsigned FILL_SEC   = 60,
    parameter int unsigned WASH_SEC   = 300,
    parameter int unsigned RINSE_SEC  = 120,
    parameter int unsigned SPIN_SEC   = 60,
    parameter int unsigned MAX_WASH   = 4,
    parameter logic [4:0]  PAUSE_MASK = 5'b10000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [1:0]                       clk_freq,
    input  logic                             coin_in,
    input  logic [clog2(MAX_WASH + 1)-1:0]   wash_count,
    input  logic                             timer_pause,
    input  logic                             abort,
    output logic [PHASE_W-1:0]               phase,
    output logic                             busy,
    output logic                             paused,
    output logic                             wash_done
);

    localparam int unsigned REP_W   = clog2(MAX_WASH + 1);
    localparam int unsigned PRE_W   = clog2(TICKS_BASE * 8);
    localparam int unsigned MAX_FW  = (FILL_SEC > WASH_SEC) ? FILL_SEC : WASH_SEC;
    localparam int unsigned MAX_RS  = (RINSE_SEC > SPIN_SEC) ? RINSE_SEC : SPIN_SEC;
    localparam int unsigned SEC_MAX = (MAX_FW > MAX_RS) ? MAX_FW : MAX_RS;
    localparam int unsigned SEC_W   = (clog2(SEC_MAX) < 1) ? 1 : clog2(SEC_MAX);

    logic [1:0]       freq_l;
    logic [REP_W-1:0] reps_left;
    logic             load;
    logic [SEC_W-1:0] load_val;
    logic             hold;
    logic             pause_en;
    logic             sec_tick;
    logic             expire;
    logic [7:0]       pause_mask8;

    assign pause_mask8 = {3'b000, PAUSE_MASK};
    assign pause_en    = timer_pause && pause_mask8[phase];
    assign hold        = (phase == IDLE) || pause_en;
    assign paused      = pause_en;
    assign busy        = (phase != IDLE);

    // Reload the timer with the next phase's length on every phase change; zero on exit.
    always_comb begin
        load     = 1'b0;
        load_val = '0;
        if (abort) begin
            load = 1'b1;
        end else begin
            case (phase)
                IDLE: begin
                    load     = coin_in;
                    load_val = SEC_W'(FILL_SEC - 1);
                end
                FILL: begin
                    load     = expire;
                    load_val = SEC_W'(WASH_SEC - 1);
                end
                WASH: begin
                    load     = expire;
                    load_val = SEC_W'(RINSE_SEC - 1);
                end
                RINSE: begin
                    load     = expire;
                    load_val = (reps_left > REP_W'(1)) ? SEC_W'(WASH_SEC - 1)
                                                       : SEC_W'(SPIN_SEC - 1);
                end
                SPIN: begin
                    load = expire;
                end
                default: begin
                    load = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= IDLE;
            wash_done <= 1'b0;
            freq_l    <= 2'b00;
            reps_left <= '0;
        end else if (abort) begin
            phase     <= IDLE;
            wash_done <= 1'b0;
        end else begin
            case (phase)
                IDLE: begin
                    if (coin_in) begin
                        freq_l    <= clk_freq;
                        wash_done <= 1'b0;
                        phase     <= FILL;
                        if (wash_count == '0) begin
                            reps_left <= REP_W'(1);
                        end else if (32'(wash_count) > MAX_WASH) begin
                            reps_left <= REP_W'(MAX_WASH);
                        end else begin
                            reps_left <= wash_count;
                        end
                    end
                end
                FILL:  if (expire) phase <= WASH;
                WASH:  if (expire) phase <= RINSE;
                RINSE: begin
                    if (expire) begin
                        if (reps_left > REP_W'(1)) begin
                            reps_left <= reps_left - 1'b1;
                            phase     <= WASH;
                        end else begin
                            phase <= SPIN;
                        end
                    end
                end
                SPIN: begin
                    if (expire) begin
                        phase     <= IDLE;
                        wash_done <= 1'b1;
                    end
                end
                default: phase <= IDLE;
            endcase
        end
    end

    wm_sec_timer #(
        .TICKS_BASE (TICKS_BASE),
        .PRE_W      (PRE_W),
        .SEC_W      (SEC_W)
    ) u_sec_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .hold     (hold),
        .freq_l   (freq_l),
        .sec_tick (sec_tick),
        .expire   (expire)
    );

endmodule

// File: tb/tb_wm_multi_cycle_controller.sv
// Directed vector bench for the washing-machine sequencer at small timing parameters.
module tb_wm_multi_cycle_controller;

    logic       clk;
    logic       rst_n;
    logic [1:0] clk_freq;
    logic       coin_in;
    logic [2:0] wash_count;
    logic       timer_pause;
    logic       abort;
    logic [2:0] phase;
    logic       busy;
    logic       paused;
    logic       wash_done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0] freq;
        logic [2:0] wc;
        bit         toggle;
        bit         coin_wash;
        int         pause_ph;
        int         pause_len;
        int         exp_total;
        int         exp_reps;
        int         exp_fill;
        int         exp_spin;
        int         exp_paused;
    } vec_t;

    vec_t vecs[10];

    wm_multi_cycle_controller #(
        .TICKS_BASE (4),
        .FILL_SEC   (2),
        .WASH_SEC   (3),
        .RINSE_SEC  (2),
        .SPIN_SEC   (2),
        .MAX_WASH   (4),
        .PAUSE_MASK (5'b10000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_freq    (clk_freq),
        .coin_in     (coin_in),
        .wash_count  (wash_count),
        .timer_pause (timer_pause),
        .abort       (abort),
        .phase       (phase),
        .busy        (busy),
        .paused      (paused),
        .wash_done   (wash_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input int ph, input string tag);
        int n;
        n = 0;
        while (int'(phase) != ph && n < 500) begin
            step();
            n++;
        end
        check(tag, int'(phase), ph);
    endtask

    task automatic run_prog(input vec_t v, input string tag);
        int len[5];
        int cycles;
        int reps;
        int pcnt;
        int pause_left;
        int p;
        int prev;
        for (int i = 0; i < 5; i++) len[i] = 0;
        clk_freq   = v.freq;
        wash_count = v.wc;
        coin_in    = 1'b1;
        step();
        coin_in = 1'b0;
        check({tag, "_fill_entry"}, int'(phase), 1);
        check({tag, "_done_clr"}, int'(wash_done), 0);
        cycles     = 0;
        reps       = 0;
        pcnt       = 0;
        pause_left = v.pause_len;
        prev       = 1;
        while (phase != 3'd0 && cycles < 2000) begin
            p = int'(phase);
            if (p == 2 && prev != 2) reps++;
            prev = p;
            if (p < 5) len[p]++;
            timer_pause = (p == v.pause_ph) && (pause_left > 0);
            if (timer_pause) pause_left--;
            coin_in = v.coin_wash && (p == 2);
            if (v.toggle) clk_freq = 2'($urandom_range(3, 0));
            #1;
            if (paused) pcnt++;
            step();
            cycles++;
        end
        timer_pause = 1'b0;
        coin_in     = 1'b0;
        clk_freq    = v.freq;
        check({tag, "_total"}, cycles, v.exp_total);
        check({tag, "_reps"}, reps, v.exp_reps);
        check({tag, "_fill_len"}, len[1], v.exp_fill);
        check({tag, "_spin_len"}, len[4], v.exp_spin);
        check({tag, "_paused_cycles"}, pcnt, v.exp_paused);
        check({tag, "_done_set"}, int'(wash_done), 1);
        check({tag, "_busy_low"}, int'(busy), 0);
        step();
        step();
        check({tag, "_done_hold"}, int'(wash_done), 1);
    endtask

    initial begin
        //          freq  wc    tog  coinW pph plen total reps fill spin paused
        vecs[0] = '{2'd0, 3'd1, 1'b0, 1'b0, 7, 0,   36,  1,   8,   8,   0};
        vecs[1] = '{2'd0, 3'd3, 1'b0, 1'b0, 7, 0,   76,  3,   8,   8,   0};
        vecs[2] = '{2'd0, 3'd0, 1'b0, 1'b0, 7, 0,   36,  1,   8,   8,   0};
        vecs[3] = '{2'd0, 3'd7, 1'b0, 1'b0, 7, 0,   96,  4,   8,   8,   0};
        vecs[4] = '{2'd3, 3'd1, 1'b0, 1'b0, 7, 0,  288,  1,  64,  64,   0};
        vecs[5] = '{2'd1, 3'd2, 1'b0, 1'b0, 7, 0,  112,  2,  16,  16,   0};
        vecs[6] = '{2'd0, 3'd1, 1'b1, 1'b0, 7, 0,   36,  1,   8,   8,   0};
        vecs[7] = '{2'd0, 3'd1, 1'b0, 1'b1, 7, 0,   36,  1,   8,   8,   0};
        vecs[8] = '{2'd0, 3'd1, 1'b0, 1'b0, 2, 10,  36,  1,   8,   8,   0};
        vecs[9] = '{2'd0, 3'd1, 1'b0, 1'b0, 4, 10,  46,  1,   8,  18,  10};

        rst_n       = 1'b0;
        clk_freq    = 2'd0;
        coin_in     = 1'b0;
        wash_count  = 3'd1;
        timer_pause = 1'b0;
        abort       = 1'b0;
        #1;
        check("reset_phase", int'(phase), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_paused", int'(paused), 0);
        check("reset_done", int'(wash_done), 0);
        #11;
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            run_prog(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort in IDLE clears a standing done flag.
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_idle_done", int'(wash_done), 0);

        // Coin together with abort must not start a programme.
        coin_in = 1'b1;
        abort   = 1'b1;
        step();
        coin_in = 1'b0;
        abort   = 1'b0;
        check("coin_abort_phase", int'(phase), 0);
        check("coin_abort_busy", int'(busy), 0);
        step();
        check("coin_abort_stay", int'(phase), 0);

        // Abort partway through RINSE.
        wash_count = 3'd1;
        coin_in    = 1'b1;
        step();
        coin_in = 1'b0;
        wait_phase(3, "abort_reach_rinse");
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_rinse_phase", int'(phase), 0);
        check("abort_rinse_busy", int'(busy), 0);
        check("abort_rinse_done", int'(wash_done), 0);
        step();
        step();
        check("abort_rinse_stay", int'(phase), 0);
        // A fresh programme after abort must see fully cleared counters.
        run_prog(vecs[0], "post_abort");

        // Asynchronous reset mid-SPIN, while paused.
        coin_in = 1'b1;
        step();
        coin_in = 1'b0;
        wait_phase(4, "rst_reach_spin");
        timer_pause = 1'b1;
        #1;
        check("rst_pre_paused", int'(paused), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_phase", int'(phase), 0);
        check("rst_async_busy", int'(busy), 0);
        check("rst_async_paused", int'(paused), 0);
        check("rst_async_done", int'(wash_done), 0);
        timer_pause = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        run_prog(vecs[0], "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
